// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: multi-lane direction predictor built on saturating counters.
// Define BP_GSHARE_EN for gshare indexing with a speculative GHR; leave it undefined for bimodal mode.
module branch_predictor_gshare #(
    parameter int ENTRIES     = 64,
    parameter int INDEX_WIDTH = $clog2(ENTRIES),
    parameter int ADDR_WIDTH  = 32,
    parameter int CTR_BITS    = 2,
    parameter int NUM_PRED    = 5,
    parameter int NUM_UPD     = 3,
    parameter int GHR_BITS    = INDEX_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PRED*ADDR_WIDTH-1:0] pred_pc_i,
    input  logic [NUM_PRED-1:0]            pred_is_branch_i,
    input  logic                           pred_fire_i,
    output logic [NUM_PRED-1:0]            pred_taken_o,
    output logic [NUM_PRED*GHR_BITS-1:0]   pred_ghr_o,
    input  logic [NUM_UPD-1:0]             upd_valid_i,
    input  logic [NUM_UPD*ADDR_WIDTH-1:0]  upd_pc_i,
    input  logic [NUM_UPD*GHR_BITS-1:0]    upd_ghr_i,
    input  logic [NUM_UPD-1:0]             upd_taken_i,
    input  logic [NUM_UPD-1:0]             upd_mispredict_i
);
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
`ifdef BP_GSHARE_EN
    localparam logic [GHR_BITS-1:0] GHR_MASK = '1;
`else
    localparam logic [GHR_BITS-1:0] GHR_MASK = '0;
`endif

    logic [CTR_BITS-1:0] r_table     [ENTRIES];
    logic [CTR_BITS-1:0] w_table_nxt [ENTRIES];
    logic [GHR_BITS-1:0] w_ghr;
    logic [GHR_BITS-1:0] w_hist_end;
    logic                w_unused;

    // A zero mask turns the hash into a plain PC index (bimodal).
    function automatic logic [INDEX_WIDTH-1:0] f_idx(input logic [INDEX_WIDTH-1:0] pc_bits,
                                                     input logic [GHR_BITS-1:0] h);
        return pc_bits ^ INDEX_WIDTH'(h & GHR_MASK);
    endfunction

    always_comb begin
        logic [GHR_BITS-1:0]    w_h;
        logic [INDEX_WIDTH-1:0] w_idx;
        logic                   w_tk;
        logic                   w_blocked;
        w_h          = w_ghr;
        w_blocked    = 1'b0;
        pred_taken_o = '0;
        pred_ghr_o   = '0;
        for (int k = 0; k < NUM_PRED; k++) begin
            w_idx           = f_idx(pred_pc_i[k*ADDR_WIDTH+2 +: INDEX_WIDTH], w_h);
            w_tk            = reset & pred_is_branch_i[k] & ~w_blocked & r_table[w_idx][CTR_BITS-1];
            pred_taken_o[k] = w_tk;
            pred_ghr_o[k*GHR_BITS +: GHR_BITS] = w_h & GHR_MASK;
            w_h             = (pred_is_branch_i[k] & ~w_blocked) ? GHR_BITS'({w_h, w_tk}) : w_h;
            w_blocked       = w_blocked | w_tk;
        end
        w_hist_end = w_h;
    end

    // Lanes apply in order so same-index updates accumulate.
    always_comb begin
        logic [INDEX_WIDTH-1:0] w_idx;
        logic [CTR_BITS-1:0]    w_c;
        for (int e = 0; e < ENTRIES; e++) w_table_nxt[e] = r_table[e];
        for (int j = 0; j < NUM_UPD; j++) begin
            w_idx = f_idx(upd_pc_i[j*ADDR_WIDTH+2 +: INDEX_WIDTH], upd_ghr_i[j*GHR_BITS +: GHR_BITS]);
            w_c   = w_table_nxt[w_idx];
            if (upd_valid_i[j])
                w_table_nxt[w_idx] = upd_taken_i[j] ? ((w_c == CTR_MAX) ? w_c : w_c + 1'b1)
                                                    : ((w_c == '0) ? w_c : w_c - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) r_table[e] <= !reset ? CTR_INIT : w_table_nxt[e];
    end

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;
    logic [GHR_BITS-1:0] w_ghr_nxt;

    assign w_ghr = r_ghr;

    // Descending scan lets the oldest mispredicting lane win recovery.
    always_comb begin
        w_ghr_nxt = pred_fire_i ? w_hist_end : r_ghr;
        for (int j = NUM_UPD - 1; j >= 0; j--)
            if (upd_valid_i[j] & upd_mispredict_i[j])
                w_ghr_nxt = GHR_BITS'({upd_ghr_i[j*GHR_BITS +: GHR_BITS], upd_taken_i[j]});
    end

    always_ff @(posedge clk) begin
        r_ghr <= !reset ? '0 : w_ghr_nxt;
    end
`else
    assign w_ghr = '0;
`endif

    assign w_unused = ^{pred_pc_i, upd_pc_i, upd_mispredict_i, pred_fire_i, w_hist_end};
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed vectors for branch_predictor_gshare in either BP_GSHARE_EN mode.
module tb_branch_predictor_gshare;
`ifdef BP_GSHARE_EN
    localparam bit GM = 1'b1;
`else
    localparam bit GM = 1'b0;
`endif
    localparam int NP = 5;
    localparam int NU = 3;
    localparam int AW = 32;
    localparam int GB = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NP*AW-1:0] pred_pc_i = '0;
    logic [NP-1:0]   pred_is_branch_i = '0;
    logic            pred_fire_i = 1'b0;
    logic [NP-1:0]   pred_taken_o;
    logic [NP*GB-1:0] pred_ghr_o;
    logic [NU-1:0]   upd_valid_i = '0;
    logic [NU*AW-1:0] upd_pc_i = '0;
    logic [NU*GB-1:0] upd_ghr_i = '0;
    logic [NU-1:0]   upd_taken_i = '0;
    logic [NU-1:0]   upd_mispredict_i = '0;
    int              n_vec = 0;
    int              n_err = 0;

    branch_predictor_gshare dut (
        .clk(clk), .reset(reset),
        .pred_pc_i(pred_pc_i), .pred_is_branch_i(pred_is_branch_i), .pred_fire_i(pred_fire_i),
        .pred_taken_o(pred_taken_o), .pred_ghr_o(pred_ghr_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_ghr_i(upd_ghr_i),
        .upd_taken_i(upd_taken_i), .upd_mispredict_i(upd_mispredict_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int k, input logic [31:0] pc, input logic br);
        pred_pc_i[k*AW +: AW] = pc;
        pred_is_branch_i[k]   = br;
    endtask

    task automatic upd(input int j, input logic [31:0] pc, input logic [5:0] g, input logic t, input logic m);
        upd_valid_i[j]        = 1'b1;
        upd_pc_i[j*AW +: AW]  = pc;
        upd_ghr_i[j*GB +: GB] = g;
        upd_taken_i[j]        = t;
        upd_mispredict_i[j]   = m;
    endtask

    task automatic idle;
        upd_valid_i      = '0;
        upd_mispredict_i = '0;
        pred_fire_i      = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NP; k++) lane(k, 32'h100 + 32'(4*k), 1'b1);
        step;
        step;
        check("rst_taken", 64'(pred_taken_o), 64'h0);
        check("rst_ghr", 64'(pred_ghr_o), 64'h0);
        reset = 1'b1;
        #1;
        check("t1_taken", 64'(pred_taken_o), 64'h0);
        check("t1_ghr", 64'(pred_ghr_o), 64'h0);
        pred_fire_i = 1'b1;
        step;
        idle;
        check("t1_fire_ghr", 64'(pred_ghr_o[5:0]), 64'h0);

        pred_is_branch_i = 5'b00001;
        lane(0, 32'h40, 1'b1);
        upd(0, 32'h40, 6'h0, 1'b1, 1'b0);
        step;
        check("t2_ctr2", 64'(pred_taken_o), 64'h1);
        step;
        upd(0, 32'h40, 6'h0, 1'b0, 1'b0);
        check("t2_ctr3", 64'(pred_taken_o), 64'h1);
        step;
        check("t2_dec2", 64'(pred_taken_o), 64'h1);
        step;
        step;
        check("t2_dec0", 64'(pred_taken_o), 64'h0);
        step;
        upd(0, 32'h40, 6'h0, 1'b1, 1'b0);
        step;
        check("t2_sat0_inc1", 64'(pred_taken_o), 64'h0);
        step;
        idle;
        check("t2_sat0_inc2", 64'(pred_taken_o), 64'h1);

        upd(0, 32'h200, 6'h0, 1'b1, 1'b0);
        upd(1, 32'h20C, 6'h1, 1'b1, 1'b0);
        step;
        idle;
        lane(0, 32'h100, 1'b0);
        lane(1, 32'h200, 1'b1);
        lane(2, 32'h104, 1'b0);
        lane(3, 32'h20C, 1'b1);
        lane(4, 32'h108, 1'b0);
        #1;
        check("t3_taken", 64'(pred_taken_o), 64'h02);
        check("t3_hist", 64'(pred_ghr_o), GM ? 64'({6'd1, 6'd1, 6'd1, 6'd0, 6'd0}) : 64'h0);
        pred_fire_i = 1'b1;
        step;
        idle;
        check("t3_ghr", 64'(pred_ghr_o[5:0]), GM ? 64'h1 : 64'h0);
        pred_is_branch_i = 5'b01000;
        #1;
        check("t3_lane3_alone", 64'(pred_taken_o), 64'h08);

        for (int k = 0; k < NP; k++) lane(k, 32'h100 + 32'(4*k), 1'b1);
        upd(0, 32'h300, 6'h05, 1'b1, 1'b1);
        upd(2, 32'h300, 6'h0A, 1'b0, 1'b1);
        pred_fire_i = 1'b1;
        step;
        idle;
        check("t4_recover", 64'(pred_ghr_o[5:0]), GM ? 64'h0B : 64'h0);

        pred_is_branch_i = 5'b00001;
        lane(0, 32'h510, 1'b1);
        upd(0, 32'h510, 6'h0B, 1'b1, 1'b0);
        upd(1, 32'h510, 6'h0B, 1'b0, 1'b0);
        step;
        idle;
        check("t5_mix", 64'(pred_taken_o), 64'h0);
        upd(0, 32'h510, 6'h0B, 1'b1, 1'b0);
        step;
        idle;
        check("t5_mix_plus", 64'(pred_taken_o), 64'h1);
        lane(0, 32'h514, 1'b1);
        upd(0, 32'h514, 6'h0B, 1'b1, 1'b0);
        step;
        check("t5_pre", 64'(pred_taken_o), 64'h1);
        for (int j = 0; j < NU; j++) upd(j, 32'h514, 6'h0B, 1'b1, 1'b0);
        step;
        idle;
        upd(0, 32'h514, 6'h0B, 1'b0, 1'b0);
        step;
        idle;
        check("t5_sat", 64'(pred_taken_o), 64'h1);
        upd(0, 32'h514, 6'h0B, 1'b0, 1'b0);
        step;
        idle;
        check("t5_dec", 64'(pred_taken_o), 64'h0);

        lane(0, 32'h510, 1'b1);
        #1;
        check("t6_pre", 64'(pred_taken_o), 64'h1);
        reset = 1'b0;
        upd(0, 32'h510, 6'h0B, 1'b1, 1'b0);
        #1;
        check("t6_forced", 64'(pred_taken_o), 64'h0);
        step;
        reset = 1'b1;
        idle;
        lane(0, 32'h200, 1'b1);
        #1;
        check("t6_clear200", 64'(pred_taken_o), 64'h0);
        check("t6_ghr", 64'(pred_ghr_o), 64'h0);
        lane(0, 32'h510, 1'b1);
        #1;
        check("t6_clear510", 64'(pred_taken_o), 64'h0);
        lane(0, 32'h200, 1'b1);
        upd(0, 32'h200, 6'h0, 1'b1, 1'b0);
        step;
        idle;
        check("t6_weak_nt", 64'(pred_taken_o), 64'h1);
        lane(0, 32'h40, 1'b1);
        upd(0, 32'h40, 6'h15, 1'b1, 1'b0);
        step;
        idle;
        check("t6_alias", 64'(pred_taken_o), GM ? 64'h0 : 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
